// File: rtl/posit_pkg.sv
// Shared posit definitions: default geometry, a constant log2 helper and the
// decoded-posit bundle used to describe values before encoding.
package posit_pkg;

  // Ceiling log2, intended for elaboration-time parameter arithmetic.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int POSIT_N  = 8;
  localparam int POSIT_ES = 3;
  localparam int POSIT_RS = log2(POSIT_N);

  typedef struct packed {
    logic                          sign;
    logic signed [POSIT_RS:0]      regime;
    logic [POSIT_ES-1:0]           exponent;
    logic [POSIT_N-POSIT_ES+2:0]   mantissa;
    logic                          zero;
    logic                          nar;
  } posit_t;

endpackage

// File: rtl/posit_round.sv
// Final encode stage: round-to-nearest-even on the truncated magnitude, regime
// clamping, special values and sign application. Purely combinational.
module posit_round
  import posit_pkg::*;
#(
  parameter int N = POSIT_N
) (
  input  logic [N-2:0] mag,
  input  logic         guard,
  input  logic         sticky,
  input  logic         sign,
  input  logic         zero,
  input  logic         nar,
  input  logic         sat_max,
  input  logic         sat_min,
  output logic [N-1:0] result,
  output logic         sat
);

  logic         round_up;
  logic [N-1:0] sum;
  logic [N-2:0] rounded;
  logic [N-2:0] mag_final;
  logic [N-1:0] mag_ext;

  always_comb begin
    round_up = guard & (sticky | mag[0]);
    sum      = {1'b0, mag} + {{(N-1){1'b0}}, round_up};

    // A carry out would land on NaR and an empty magnitude would read as zero;
    // neither is a legal rounding of a real nonzero value.
    if (sum[N-1])
      rounded = '1;
    else if (sum[N-2:0] == '0)
      rounded = {{(N-2){1'b0}}, 1'b1};
    else
      rounded = sum[N-2:0];

    if (sat_max)
      mag_final = '1;
    else if (sat_min)
      mag_final = {{(N-2){1'b0}}, 1'b1};
    else
      mag_final = rounded;

    mag_ext = {1'b0, mag_final};

    if (nar)
      result = {1'b1, {(N-1){1'b0}}};
    else if (zero)
      result = '0;
    else if (sign)
      result = -mag_ext;
    else
      result = mag_ext;

    sat = !nar && !zero && (sat_max || sat_min);
  end

endmodule

// File: rtl/posit_encode_pipe.sv
// Pipelined posit encoder: decoded fields (sign, signed regime k, exponent,
// hidden-bit mantissa) in, rounded N-bit posit out over three valid/ready stages.
module posit_encode_pipe
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = log2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            Sign,
  input  logic [RS:0]     RegimeValue,
  input  logic [ES-1:0]   Exponent,
  input  logic [N-ES+2:0] Mantissa,
  input  logic            InZero,
  input  logic            InNaR,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    Result,
  output logic            Sat
);

  localparam int LW = RS + 2;   // wide enough for regime string lengths up to N
  localparam int TW = N + 2;    // exponent plus fraction with hidden bit dropped
  localparam int FW = N + TW;

  logic s1_valid, s2_valid, s3_valid;
  logic s1_adv, s2_adv, s3_adv;

  assign s3_adv    = !s3_valid || out_ready;
  assign s2_adv    = !s2_valid || s3_adv;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s3_valid;

  // ---------------- S1: regime build ----------------
  int            k_int;
  int            run_int;
  logic          reg_pos;
  logic          sat_max;
  logic          sat_min;
  logic [LW-1:0] run_len;
  logic [N-1:0]  reg_field;

  always_comb begin
    k_int   = int'($signed(RegimeValue));
    reg_pos = (k_int >= 0);
    run_int = reg_pos ? (k_int + 1) : -k_int;
    // Over-long runs only occur for clamped values, so the string contents no longer matter.
    if (run_int > N - 1) run_int = N - 1;
    run_len = LW'(run_int);
    sat_max = (k_int >= N - 2);
    sat_min = (k_int <= -(N - 1));
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_regime
    assign reg_field[N-1-gi] = (LW'(gi) < run_len)  ? reg_pos  :
                               (LW'(gi) == run_len) ? !reg_pos : 1'b0;
  end

  logic [N-1:0]  s1_field;
  logic [LW-1:0] s1_len;
  logic [TW-1:0] s1_tail;
  logic          s1_sign, s1_zero, s1_nar, s1_sat_max, s1_sat_min;

  // ---------------- S2: concatenate, truncate, guard/sticky ----------------
  logic [LW-1:0] shamt;
  logic [FW-1:0] full;

  assign shamt = LW'(N) - s1_len;
  assign full  = {s1_field, {TW{1'b0}}} | ({{N{1'b0}}, s1_tail} << shamt);

  logic [N-2:0] s2_mag;
  logic         s2_guard, s2_sticky;
  logic         s2_sign, s2_zero, s2_nar, s2_sat_max, s2_sat_min;

  // ---------------- S3: round, saturate, sign ----------------
  logic [N-1:0] rnd_result;
  logic         rnd_sat;

  posit_round #(.N(N)) u_round (
    .mag     (s2_mag),
    .guard   (s2_guard),
    .sticky  (s2_sticky),
    .sign    (s2_sign),
    .zero    (s2_zero),
    .nar     (s2_nar),
    .sat_max (s2_sat_max),
    .sat_min (s2_sat_min),
    .result  (rnd_result),
    .sat     (rnd_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      s1_field   <= '0;
      s1_len     <= '0;
      s1_tail    <= '0;
      s1_sign    <= 1'b0;
      s1_zero    <= 1'b0;
      s1_nar     <= 1'b0;
      s1_sat_max <= 1'b0;
      s1_sat_min <= 1'b0;
      s2_mag     <= '0;
      s2_guard   <= 1'b0;
      s2_sticky  <= 1'b0;
      s2_sign    <= 1'b0;
      s2_zero    <= 1'b0;
      s2_nar     <= 1'b0;
      s2_sat_max <= 1'b0;
      s2_sat_min <= 1'b0;
      Result     <= '0;
      Sat        <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_field   <= reg_field;
          s1_len     <= run_len + LW'(1);
          s1_tail    <= {Exponent, Mantissa[N-ES+1:0]};
          s1_sign    <= Sign;
          s1_nar     <= InNaR;
          s1_zero    <= InZero && !InNaR;
          s1_sat_max <= sat_max;
          s1_sat_min <= sat_min;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_mag     <= full[FW-1 -: N-1];
          s2_guard   <= full[FW-N];
          s2_sticky  <= |full[FW-N-1:0];
          s2_sign    <= s1_sign;
          s2_zero    <= s1_zero;
          s2_nar     <= s1_nar;
          s2_sat_max <= s1_sat_max;
          s2_sat_min <= s1_sat_min;
        end
      end
      if (s3_adv) begin
        s3_valid <= s2_valid;
        if (s2_valid) begin
          Result <= rnd_result;
          Sat    <= rnd_sat;
        end
      end
    end
  end

endmodule
